// File: rtl/nf10_axis_input_arbiter.sv
// Five-input AXI4-Stream packet arbiter: round-robin grant per packet,
// single registered output stage with one-cycle latency.
module nf10_axis_input_arbiter #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
  input  logic                                axi_aclk,
  input  logic                                axi_resetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata_0,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tstrb_0,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser_0,
  input  logic                                s_axis_tvalid_0,
  output logic                                s_axis_tready_0,
  input  logic                                s_axis_tlast_0,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata_1,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tstrb_1,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser_1,
  input  logic                                s_axis_tvalid_1,
  output logic                                s_axis_tready_1,
  input  logic                                s_axis_tlast_1,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata_2,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tstrb_2,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser_2,
  input  logic                                s_axis_tvalid_2,
  output logic                                s_axis_tready_2,
  input  logic                                s_axis_tlast_2,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata_3,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tstrb_3,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser_3,
  input  logic                                s_axis_tvalid_3,
  output logic                                s_axis_tready_3,
  input  logic                                s_axis_tlast_3,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata_4,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tstrb_4,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser_4,
  input  logic                                s_axis_tvalid_4,
  output logic                                s_axis_tready_4,
  input  logic                                s_axis_tlast_4,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready,
  output logic                                m_axis_tlast
);

  localparam int DW = C_S_AXIS_DATA_WIDTH;
  localparam int SW = C_S_AXIS_DATA_WIDTH / 8;
  localparam int UW = C_S_AXIS_TUSER_WIDTH;

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t      state_r, state_nxt_s;
  logic [2:0]  rr_ptr_r, rr_ptr_nxt_s;
  logic [2:0]  grant_r, grant_nxt_s;
  logic [2:0]  pick_s;
  logic        found_s;
  logic        out_free_s;
  logic        accept_s;
  logic [4:0]  ready_s;

  logic [DW-1:0] in_tdata [5];
  logic [SW-1:0] in_tstrb [5];
  logic [UW-1:0] in_tuser [5];
  logic [4:0]    in_tvalid;
  logic [4:0]    in_tlast;

  assign in_tdata[0] = s_axis_tdata_0;
  assign in_tdata[1] = s_axis_tdata_1;
  assign in_tdata[2] = s_axis_tdata_2;
  assign in_tdata[3] = s_axis_tdata_3;
  assign in_tdata[4] = s_axis_tdata_4;
  assign in_tstrb[0] = s_axis_tstrb_0;
  assign in_tstrb[1] = s_axis_tstrb_1;
  assign in_tstrb[2] = s_axis_tstrb_2;
  assign in_tstrb[3] = s_axis_tstrb_3;
  assign in_tstrb[4] = s_axis_tstrb_4;
  assign in_tuser[0] = s_axis_tuser_0;
  assign in_tuser[1] = s_axis_tuser_1;
  assign in_tuser[2] = s_axis_tuser_2;
  assign in_tuser[3] = s_axis_tuser_3;
  assign in_tuser[4] = s_axis_tuser_4;
  assign in_tvalid = {s_axis_tvalid_4, s_axis_tvalid_3, s_axis_tvalid_2, s_axis_tvalid_1, s_axis_tvalid_0};
  assign in_tlast  = {s_axis_tlast_4, s_axis_tlast_3, s_axis_tlast_2, s_axis_tlast_1, s_axis_tlast_0};

  // Port index base+off, modulo 5.
  function automatic logic [2:0] wrap_add(input logic [2:0] base, input logic [2:0] off);
    logic [3:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    sum = (sum >= 4'd5) ? (sum - 4'd5) : sum;
    return sum[2:0];
  endfunction

  assign out_free_s = !m_axis_tvalid || m_axis_tready;
  assign accept_s   = (state_r == XFER) && out_free_s && in_tvalid[grant_r];

  // Cyclic search from rr_ptr; descending loop so the nearest port wins.
  always_comb begin
    found_s = 1'b0;
    pick_s  = 3'd0;
    for (int k = 4; k >= 0; k--) begin
      if (in_tvalid[wrap_add(rr_ptr_r, k[2:0])]) begin
        found_s = 1'b1;
        pick_s  = wrap_add(rr_ptr_r, k[2:0]);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Only the granted port sees ready, and only while the output stage can take a beat.
  always_comb begin
    ready_s = 5'b0;
    if (state_r == XFER) begin
      ready_s[grant_r] = out_free_s;
    end else begin
      ready_s = 5'b0;
    end
  end

  assign s_axis_tready_0 = ready_s[0];
  assign s_axis_tready_1 = ready_s[1];
  assign s_axis_tready_2 = ready_s[2];
  assign s_axis_tready_3 = ready_s[3];
  assign s_axis_tready_4 = ready_s[4];

  // Next-state logic: grant is held until the last beat of the packet is accepted.
  always_comb begin
    state_nxt_s  = state_r;
    grant_nxt_s  = grant_r;
    rr_ptr_nxt_s = rr_ptr_r;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_nxt_s = XFER;
          grant_nxt_s = pick_s;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      XFER: begin
        if (accept_s && in_tlast[grant_r]) begin
          state_nxt_s  = IDLE;
          rr_ptr_nxt_s = wrap_add(grant_r, 3'd1);
        end else begin
          state_nxt_s = XFER;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_r  <= IDLE;
      rr_ptr_r <= 3'd0;
      grant_r  <= 3'd0;
    end else begin
      state_r  <= state_nxt_s;
      rr_ptr_r <= rr_ptr_nxt_s;
      grant_r  <= grant_nxt_s;
    end
  end

  // Output stage: loads whenever empty or draining, holds while stalled.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tstrb  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (out_free_s) begin
      m_axis_tvalid <= accept_s;
      if (accept_s) begin
        m_axis_tdata <= in_tdata[grant_r];
        m_axis_tstrb <= in_tstrb[grant_r];
        m_axis_tuser <= in_tuser[grant_r];
        m_axis_tlast <= in_tlast[grant_r];
      end
    end
  end

endmodule

// File: tb/tb_nf10_axis_input_arbiter.sv
// Bench for nf10_axis_input_arbiter: per-port packet drivers, a round-robin
// packet-order model, and per-cycle protocol checks on both sides.
module tb_nf10_axis_input_arbiter;

  localparam int DW = 256;
  localparam int SW = 32;
  localparam int UW = 128;

  typedef struct {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic [UW-1:0] user;
    logic          last;
    int            gap;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] s_tdata [5];
  logic [SW-1:0] s_tstrb [5];
  logic [UW-1:0] s_tuser [5];
  logic [4:0]    s_tvalid;
  logic [4:0]    s_tlast;
  wire  [4:0]    s_tready;
  logic [DW-1:0] m_tdata;
  logic [SW-1:0] m_tstrb;
  logic [UW-1:0] m_tuser;
  logic          m_tvalid, m_tlast;
  logic          m_tready;

  nf10_axis_input_arbiter dut (
    .axi_aclk(clk), .axi_resetn(rst_n),
    .s_axis_tdata_0(s_tdata[0]), .s_axis_tstrb_0(s_tstrb[0]), .s_axis_tuser_0(s_tuser[0]),
    .s_axis_tvalid_0(s_tvalid[0]), .s_axis_tready_0(s_tready[0]), .s_axis_tlast_0(s_tlast[0]),
    .s_axis_tdata_1(s_tdata[1]), .s_axis_tstrb_1(s_tstrb[1]), .s_axis_tuser_1(s_tuser[1]),
    .s_axis_tvalid_1(s_tvalid[1]), .s_axis_tready_1(s_tready[1]), .s_axis_tlast_1(s_tlast[1]),
    .s_axis_tdata_2(s_tdata[2]), .s_axis_tstrb_2(s_tstrb[2]), .s_axis_tuser_2(s_tuser[2]),
    .s_axis_tvalid_2(s_tvalid[2]), .s_axis_tready_2(s_tready[2]), .s_axis_tlast_2(s_tlast[2]),
    .s_axis_tdata_3(s_tdata[3]), .s_axis_tstrb_3(s_tstrb[3]), .s_axis_tuser_3(s_tuser[3]),
    .s_axis_tvalid_3(s_tvalid[3]), .s_axis_tready_3(s_tready[3]), .s_axis_tlast_3(s_tlast[3]),
    .s_axis_tdata_4(s_tdata[4]), .s_axis_tstrb_4(s_tstrb[4]), .s_axis_tuser_4(s_tuser[4]),
    .s_axis_tvalid_4(s_tvalid[4]), .s_axis_tready_4(s_tready[4]), .s_axis_tlast_4(s_tlast[4]),
    .m_axis_tdata(m_tdata), .m_axis_tstrb(m_tstrb), .m_axis_tuser(m_tuser),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast)
  );

  beat_t src_q [5][$];
  beat_t pend_q [5][$];
  beat_t exp_out [$];
  int    exp_in [$];
  int    out_cyc [$];
  int    out_port [$];
  int    in_cyc [$];
  int    gap [5];
  int    mdl_ptr = 0;
  int    cyc = 0;
  int    rdy_mode = 0;
  int    lo_start = 0;
  int    stall_cnt = 0;
  int    passed = 0;
  int    total = 0;
  logic          hold_prev = 1'b0;
  logic [DW-1:0] sv_data;
  logic [SW-1:0] sv_strb;
  logic [UW-1:0] sv_user;
  logic          sv_last;

  function automatic beat_t make_beat(input int port, input logic last, input int g);
    beat_t b;
    for (int w = 0; w < DW / 32; w++) b.data[w*32 +: 32] = $urandom;
    b.strb = {$urandom};
    for (int w = 0; w < UW / 32; w++) b.user[w*32 +: 32] = $urandom;
    b.user[2:0] = port[2:0];
    b.last = last;
    b.gap  = g;
    return b;
  endfunction

  // force_gap > 0 puts exactly that many invalid cycles after beat 0.
  task automatic load_pkt(input int port, input int len, input int gap_pct, input int force_gap);
    beat_t b;
    int g;
    for (int k = 0; k < len; k++) begin
      g = 0;
      if (k < len - 1 && $urandom_range(0, 99) < gap_pct) g = $urandom_range(1, 2);
      if (k == 0 && force_gap > 0) g = force_gap;
      b = make_beat(port, (k == len - 1), g);
      src_q[port].push_back(b);
      pend_q[port].push_back(b);
    end
  endtask

  // Reference order: whole packets, next port = first with pending work at or after mdl_ptr.
  task automatic plan();
    beat_t b;
    int p;
    forever begin
      p = -1;
      for (int k = 0; k < 5; k++)
        if (p < 0 && pend_q[(mdl_ptr + k) % 5].size() > 0) p = (mdl_ptr + k) % 5;
      if (p < 0) break;
      do begin
        b = pend_q[p].pop_front();
        exp_out.push_back(b);
        exp_in.push_back(p);
      end while (!b.last);
      mdl_ptr = (p + 1) % 5;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 5; i++) begin
      if (src_q[i].size() > 0) begin
        s_tvalid[i] = (gap[i] == 0);
        s_tdata[i]  = src_q[i][0].data;
        s_tstrb[i]  = src_q[i][0].strb;
        s_tuser[i]  = src_q[i][0].user;
        s_tlast[i]  = src_q[i][0].last;
      end else begin
        s_tvalid[i] = 1'b0;
        s_tdata[i]  = '0;
        s_tstrb[i]  = '0;
        s_tuser[i]  = '0;
        s_tlast[i]  = 1'b0;
      end
    end
    case (rdy_mode)
      1:       m_tready = ($urandom_range(0, 3) != 0);
      2:       m_tready = !(cyc >= lo_start && cyc < lo_start + 4);
      default: m_tready = 1'b1;
    endcase
  endtask

  task automatic clear_model();
    for (int i = 0; i < 5; i++) begin
      src_q[i].delete();
      pend_q[i].delete();
      gap[i] = 0;
    end
    exp_out.delete();
    exp_in.delete();
    mdl_ptr = 0;
    hold_prev = 1'b0;
  endtask

  // One clock: check both sides at the negedge, then advance drivers after the posedge.
  task automatic step();
    logic [4:0] hs;
    int ep;
    beat_t e;
    beat_t b;
    @(negedge clk);
    hs = s_tvalid & s_tready;
    ep = (exp_in.size() > 0) ? exp_in[0] : -1;
    total++;
    if ((s_tready & ~(ep >= 0 ? (5'b1 << ep) : 5'b0)) != 5'b0 || (m_tvalid && !m_tready && s_tready != 5'b0))
      $display("FAIL tready_legal: s_tready=%b, allowed port %0d, out stalled=%0b", s_tready, ep, m_tvalid && !m_tready);
    else passed++;
    for (int i = 0; i < 5; i++) begin
      if (hs[i]) begin
        total++;
        if (exp_in.size() == 0 || exp_in[0] != i)
          $display("FAIL in_order: accepted port %0d, expected port %0d", i, ep);
        else begin
          passed++;
          void'(exp_in.pop_front());
          in_cyc.push_back(cyc);
        end
      end
    end
    if (hold_prev) begin
      total++;
      if (!m_tvalid || m_tdata !== sv_data || m_tstrb !== sv_strb || m_tuser !== sv_user || m_tlast !== sv_last)
        $display("FAIL hold_stable: tvalid=%0b user=%h last=%0b, held user=%h last=%0b", m_tvalid, m_tuser, m_tlast, sv_user, sv_last);
      else passed++;
    end
    if (m_tvalid && m_tready) begin
      total++;
      if (exp_out.size() == 0) begin
        $display("FAIL out_extra: unexpected beat user=%h", m_tuser);
      end else begin
        e = exp_out.pop_front();
        if (m_tdata !== e.data || m_tstrb !== e.strb || m_tuser !== e.user || m_tlast !== e.last)
          $display("FAIL out_beat: got user=%h last=%0b strb=%h, want user=%h last=%0b strb=%h",
                   m_tuser, m_tlast, m_tstrb, e.user, e.last, e.strb);
        else passed++;
      end
      out_cyc.push_back(cyc);
      out_port.push_back(int'(m_tuser[2:0]));
    end
    if (m_tvalid && !m_tready) stall_cnt++;
    hold_prev = m_tvalid && !m_tready;
    sv_data = m_tdata; sv_strb = m_tstrb; sv_user = m_tuser; sv_last = m_tlast;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 5; i++) begin
      if (hs[i] && src_q[i].size() > 0) begin
        b = src_q[i].pop_front();
        gap[i] = b.gap;
      end else if (gap[i] > 0) gap[i]--;
    end
    drive();
  endtask

  task automatic run(input int max_cycles);
    int n = 0;
    while ((exp_out.size() > 0 || exp_in.size() > 0) && n < max_cycles) begin
      step();
      n++;
    end
    total++;
    if (exp_out.size() > 0 || exp_in.size() > 0)
      $display("FAIL run_timeout: %0d output and %0d input beats outstanding", exp_out.size(), exp_in.size());
    else passed++;
  endtask

  task automatic start_run();
    plan();
    drive();
    out_cyc.delete();
    out_port.delete();
    in_cyc.delete();
  endtask

  // Reset with every input valid: nothing may be granted or output.
  task automatic test_reset();
    rst_n = 1'b0;
    clear_model();
    rdy_mode = 0;
    drive();
    s_tvalid = 5'h1f;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (m_tvalid !== 1'b0 || s_tready !== 5'b0 || m_tdata !== '0 || m_tstrb !== '0 || m_tuser !== '0 || m_tlast !== 1'b0)
      $display("FAIL reset_state: m_tvalid=%0b s_tready=%b m_tlast=%0b, want all zero", m_tvalid, s_tready, m_tlast);
    else passed++;
    s_tvalid = 5'h00;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (m_tvalid !== 1'b0 || s_tready !== 5'b0)
      $display("FAIL reset_release: m_tvalid=%0b s_tready=%b, want 0/00000", m_tvalid, s_tready);
    else passed++;
  endtask

  task automatic test_single_port();
    test_reset();
    load_pkt(2, 3, 0, 0);
    start_run();
    run(50);
    total++;
    if (out_cyc.size() != 3 || in_cyc.size() != 3 || out_cyc[0] != in_cyc[0] + 1 ||
        out_cyc[1] != in_cyc[1] + 1 || out_cyc[2] != in_cyc[2] + 1 || out_cyc[2] != out_cyc[0] + 2)
      $display("FAIL single_latency: %0d beats out, first in/out cycle %0d/%0d", out_cyc.size(),
               in_cyc.size() > 0 ? in_cyc[0] : -1, out_cyc.size() > 0 ? out_cyc[0] : -1);
    else passed++;
    load_pkt(2, 1, 0, 0);
    load_pkt(3, 1, 0, 0);
    start_run();
    run(50);
    total++;
    if (out_port.size() != 2 || out_port[0] != 3)
      $display("FAIL rr_after_port2: first port %0d, want 3", out_port.size() > 0 ? out_port[0] : -1);
    else passed++;
  endtask

  task automatic test_round_robin();
    int want [6] = '{0, 1, 2, 3, 4, 0};
    logic bad = 1'b0;
    test_reset();
    for (int p = 0; p < 5; p++) load_pkt(p, 1, 0, 0);
    load_pkt(0, 1, 0, 0);
    start_run();
    run(60);
    total++;
    if (out_port.size() != 6) bad = 1'b1;
    for (int k = 0; k < 6 && !bad; k++) begin
      if (out_port[k] != want[k]) bad = 1'b1;
      if (k > 0 && out_cyc[k] != out_cyc[k-1] + 2) bad = 1'b1;
    end
    if (bad) $display("FAIL round_robin: %0d beats, order/spacing differs from 0,1,2,3,4,0 every 2 cycles", out_port.size());
    else passed++;
  endtask

  task automatic test_backpressure();
    test_reset();
    rdy_mode = 2;
    lo_start = cyc + 2;
    load_pkt(1, 4, 0, 0);
    start_run();
    stall_cnt = 0;
    run(60);
    rdy_mode = 0;
    total++;
    if (stall_cnt != 4 || out_port.size() != 4)
      $display("FAIL backpressure: stall cycles %0d want 4, beats %0d want 4", stall_cnt, out_port.size());
    else passed++;
  endtask

  task automatic test_bubble();
    test_reset();
    load_pkt(2, 1, 0, 0);
    start_run();
    run(30);
    load_pkt(3, 3, 0, 2);
    load_pkt(0, 1, 0, 0);
    start_run();
    run(60);
    total++;
    if (out_port.size() != 4 || out_port[0] != 3 || out_port[2] != 3 || out_port[3] != 0 || out_cyc[1] != out_cyc[0] + 3)
      $display("FAIL bubble: %0d beats, last port %0d, beat gap %0d want 3", out_port.size(),
               out_port.size() > 3 ? out_port[3] : -1, out_cyc.size() > 1 ? out_cyc[1] - out_cyc[0] : -1);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    test_reset();
    load_pkt(4, 3, 0, 0);
    start_run();
    while (src_q[4].size() > 2 && n < 20) begin
      step();
      n++;
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (m_tvalid !== 1'b0 || s_tready !== 5'b0 || m_tdata !== '0 || m_tlast !== 1'b0)
      $display("FAIL reset_mid: m_tvalid=%0b s_tready=%b after %0d cycles, want 0/00000", m_tvalid, s_tready, n);
    else passed++;
    clear_model();
    drive();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    load_pkt(4, 1, 0, 0);
    load_pkt(0, 1, 0, 0);
    start_run();
    run(40);
    total++;
    if (out_port.size() != 2 || out_port[0] != 0)
      $display("FAIL reset_restart: first port %0d want 0", out_port.size() > 0 ? out_port[0] : -1);
    else passed++;
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      for (int p = 0; p < 5; p++) begin
        int npk = $urandom_range(0, 3);
        for (int k = 0; k < npk; k++) load_pkt(p, $urandom_range(1, 4), 30, 0);
      end
      rdy_mode = 1;
      start_run();
      run(3000);
      rdy_mode = 0;
    end
  endtask

  initial begin
    for (int i = 0; i < 5; i++) gap[i] = 0;
    m_tready = 1'b1;
    drive();
    test_reset();
    test_single_port();
    test_round_robin();
    test_backpressure();
    test_bubble();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/nf10_axis_input_arbiter.md
NF10_AXIS_INPUT_ARBITER -- requirements
Module: nf10_axis_input_arbiter

Interface
REQ-001 Parameter C_M_AXIS_DATA_WIDTH, default 256: master AXI4-Stream tdata width.
REQ-002 Parameter C_S_AXIS_DATA_WIDTH, default 256: slave tdata width; SHALL equal C_M_AXIS_DATA_WIDTH.
REQ-003 Parameter C_M_AXIS_TUSER_WIDTH, default 128: master tuser width.
REQ-004 Parameter C_S_AXIS_TUSER_WIDTH, default 128: slave tuser width; SHALL equal C_M_AXIS_TUSER_WIDTH.
REQ-005 Clocking SHALL be one clock; reset SHALL be asynchronous and active-low.
REQ-006 axi_aclk  input  1  sole clock; all state changes on its rising edge.
REQ-007 axi_resetn  input  1  asynchronous active-low reset.
REQ-008 s_axis_tdata_i (i=0..4)  input  C_S_AXIS_DATA_WIDTH  slave port i data.
REQ-009 s_axis_tstrb_i  input  C_S_AXIS_DATA_WIDTH/8  slave port i byte strobes.
REQ-010 s_axis_tuser_i  input  C_S_AXIS_TUSER_WIDTH  slave port i sideband (metadata, beat 1).
REQ-011 s_axis_tvalid_i  input  1  slave port i beat valid.
REQ-012 s_axis_tready_i  output  1  slave port i ready.
REQ-013 s_axis_tlast_i  input  1  slave port i last beat of packet.
REQ-014 m_axis_tdata  output  C_M_AXIS_DATA_WIDTH  merged output data.
REQ-015 m_axis_tstrb  output  C_M_AXIS_DATA_WIDTH/8  merged output strobes.
REQ-016 m_axis_tuser  output  C_M_AXIS_TUSER_WIDTH  merged output sideband.
REQ-017 m_axis_tvalid  output  1  output beat valid.
REQ-018 m_axis_tready  input  1  downstream ready.
REQ-019 m_axis_tlast  output  1  output last beat.

Function
REQ-020 States SHALL be IDLE and XFER; 3-bit rr_ptr (0..4) and 3-bit grant registers.
REQ-021 IDLE: if any s_axis_tvalid_i, grant SHALL load the first asserting port searching cyclically from rr_ptr; next state XFER; else stay IDLE.
REQ-022 IDLE: every s_axis_tready_i SHALL be 0.
REQ-023 XFER: s_axis_tready_grant SHALL = (!m_axis_tvalid || m_axis_tready); all other s_axis_tready_i SHALL be 0.
REQ-024 Beat accepted (tvalid&tready on granted port) at edge N SHALL appear on m_axis_* (tdata, tstrb, tuser, tlast unchanged) from edge N, i.e. registered one-stage output, 1-cycle latency.
REQ-025 Output register SHALL load when (!m_axis_tvalid || m_axis_tready); m_axis_tvalid SHALL clear when m_axis_tready and no new beat accepted; m_axis_* SHALL hold stable while m_axis_tvalid && !m_axis_tready.
REQ-026 Grant SHALL be held for the whole packet; granted-port tvalid deasserting mid-packet SHALL produce output bubbles, never a switch.
REQ-027 Accepted beat with tlast=1: rr_ptr SHALL become (grant+1) mod 5 (4 wraps to 0); next state IDLE.
REQ-028 Single-beat packets SHALL be legal; minimum one IDLE cycle between consecutive grants.
REQ-029 Packets from different ports SHALL never interleave; no beat SHALL be dropped or duplicated.
REQ-030 Input tvalid asserted on non-granted ports SHALL be held off without affecting the current packet.

Reset
REQ-031 axi_resetn low SHALL immediately force state=IDLE, rr_ptr=0, grant=0, m_axis_tvalid=0, all s_axis_tready_i=0; m_axis_tdata/tstrb/tuser/tlast=0.
REQ-032 Reset mid-packet SHALL discard the partial packet and in-flight output beat; first grant after release SHALL start search at port 0.

Verification
REQ-033 Port 2 sends 3-beat packet, m_axis_tready=1 -> grant 2, beats on m_axis one cycle after acceptance, tlast on beat 3, rr_ptr=3.
REQ-034 Ports 0..4 all valid from reset, 1-beat packets each -> output order 0,1,2,3,4,0 (wrap), one IDLE cycle between each.
REQ-035 Port 1 mid-packet, m_axis_tready low 4 cycles -> m_axis_* stable, s_axis_tready_1=0 after output full, resumes with no loss.
REQ-036 Port 3 drops tvalid 2 cycles mid-packet while port 0 valid -> 2 output bubbles, port 0 served only after port 3 tlast.
REQ-037 axi_resetn pulsed low during port 4 beat 2 -> m_axis_tvalid=0 same cycle, all tready 0; after release, ports 4 and 0 valid -> port 0 granted first.
